// File: rtl/demod_pkg.sv
// demod_pkg: shared sizing and seg_bus slice helpers for the demod frame scheduler
package demod_pkg;
  localparam int SEGMENTS = 10;
  localparam int DATA_W = 32;
  localparam int DEMOD_LATENCY = 14;
  localparam int FIFO_DEPTH = 4;
  localparam int BUS_W = SEGMENTS * DATA_W;
  function automatic int seg_lo(input int k);
    return k * DATA_W;
  endfunction
endpackage

// File: rtl/demod_result_fifo.sv
// demod_result_fifo: registered first-word fall-through buffer for pipeline results
module demod_result_fifo #(
  parameter int DATA_W = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [DATA_W-1:0]            data,
  output logic [$clog2(FIFO_DEPTH):0]  count,
  output logic                         empty,
  output logic                         full
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign do_pop = pop && !empty;
  assign data = empty ? '0 : mem[rd];
  always_ff @(posedge clk)
    if (push) mem[wr] <= push_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/demod_frame_scheduler.sv
// demod_frame_scheduler: frame assembly, credit-gated issue and result buffering around the demod pipeline
module demod_frame_scheduler
  import demod_pkg::*;
#(
  parameter int SEGMENTS = demod_pkg::SEGMENTS,
  parameter int DATA_W = demod_pkg::DATA_W,
  parameter int LATENCY = demod_pkg::DEMOD_LATENCY,
  parameter int FIFO_DEPTH = demod_pkg::FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [SEGMENTS*DATA_W-1:0] seg_bus,
  output logic                       issue,
  input  logic [DATA_W-1:0]          pipe_result,
  output logic [DATA_W-1:0]          m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       busy,
  output logic [15:0]                frames_done
);
  localparam int IW = $clog2(SEGMENTS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IW-1:0] LAST = IW'(SEGMENTS - 1);
  logic [IW-1:0] idx;
  logic [(SEGMENTS-1)*DATA_W-1:0] asm_q;
  logic hold_valid;
  logic [LATENCY-1:0] tokens;
  logic [CW-1:0] credits, fifo_count;
  logic last, accept, push, pop, fifo_empty, fifo_full;
  assign last = idx == LAST;
  // the final segment may land in the same cycle the held frame leaves
  assign s_ready = !(last && hold_valid && !issue);
  assign accept = s_valid && s_ready;
  assign issue = hold_valid && credits != '0;
  assign push = tokens[LATENCY-1] && !fifo_full;
  assign m_valid = !fifo_empty;
  assign pop = m_valid && m_ready;
  assign busy = idx != '0 || hold_valid || tokens != '0 || fifo_count != '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      idx <= '0;
      asm_q <= '0;
      seg_bus <= '0;
      hold_valid <= 1'b0;
      tokens <= '0;
      credits <= CW'(FIFO_DEPTH);
      frames_done <= '0;
    end else begin
      if (accept) begin
        idx <= last ? '0 : idx + 1'b1;
        if (last) seg_bus <= {s_data, asm_q};
        else asm_q[idx*DATA_W +: DATA_W] <= s_data;
      end
      hold_valid <= (accept && last) || (hold_valid && !issue);
      tokens <= {tokens[LATENCY-2:0], issue};
      // credits reserve a FIFO slot for every frame issued into the non-stallable pipe
      credits <= credits - CW'(issue) + CW'(pop);
      if (pop) frames_done <= frames_done + 1'b1;
    end
  demod_result_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .push_data(pipe_result),
    .pop(pop),
    .data(m_data),
    .count(fifo_count),
    .empty(fifo_empty),
    .full(fifo_full)
  );
endmodule

// File: tb/tb_demod_frame_scheduler.sv
// tb_demod_frame_scheduler: directed checks of assembly, issue timing, credits and result ordering
module tb_demod_frame_scheduler;
  import demod_pkg::*;
  localparam int LAT = DEMOD_LATENCY;
  logic clk = 0, reset = 0;
  logic [DATA_W-1:0] s_data = '0, pipe_result, m_data;
  logic s_valid = 0, s_ready, issue, m_valid, m_ready = 1, busy;
  logic [BUS_W-1:0] seg_bus;
  logic [15:0] frames_done;
  logic [DATA_W-1:0] pipe [LAT];
  int passed = 0, total = 0, cyc = 0, issues = 0, stalls = 0;
  int issue_cyc[$];
  logic [DATA_W-1:0] got[$];
  logic inv_en = 0, both_seen = 0, both_any = 0;
  logic [3:0] both_cred = '0;
  always #5 clk = ~clk;
  demod_frame_scheduler dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .seg_bus(seg_bus), .issue(issue), .pipe_result(pipe_result), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .frames_done(frames_done)
  );
  // pipeline stand-in: result = segment 0 + segment 9, valid LAT cycles after issue
  always @(posedge clk) begin
    pipe[0] <= seg_bus[seg_lo(0) +: DATA_W] + seg_bus[seg_lo(SEGMENTS-1) +: DATA_W];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign pipe_result = pipe[LAT-1];
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (issue) begin
        issues++;
        issue_cyc.push_back(cyc);
      end
      if (m_valid && m_ready) got.push_back(m_data);
      if (s_valid && !s_ready) stalls++;
      if (inv_en) check("invariant", 64'(dut.credits + $countones(dut.tokens) + dut.fifo_count), 4);
      if (dut.tokens[LAT-1]) check("no_overflow", dut.fifo_full, 0);
      if (both_seen) check("pop_issue_credits", dut.credits, both_cred);
      both_seen = issue && m_valid && m_ready;
      both_any = both_any || both_seen;
      both_cred = 4'(dut.credits);
    end else both_seen = 0;
  end
  task automatic send_seg(input logic [DATA_W-1:0] d);
    logic acc;
    int n;
    n = 0;
    s_valid = 1;
    s_data = d;
    do begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 300);
    if (!acc) check("send_timeout", acc, 1);
  endtask
  task automatic send_frame(input int b);
    for (int k = 0; k < SEGMENTS; k++) send_seg(DATA_W'(b + k));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    #1 reset = 1;
    #20;
    check("rst_s_ready", s_ready, 1);
    check("rst_issue", issue, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frames_done", frames_done, 0);
    check("rst_seg_bus", seg_bus == '0, 1);
    check("rst_credits", dut.credits, 4);
    @(posedge clk);
    #1 reset = 0;
    inv_en = 1;
    // single frame, segments 1..10
    issues = 0;
    send_frame(1);
    s_valid = 0;
    check("issue_t1", issue, 1);
    check("slice0", seg_bus[seg_lo(0) +: DATA_W], 1);
    check("slice9", seg_bus[seg_lo(9) +: DATA_W], 10);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (m_valid) break;
      n++;
    end
    check("result_latency", n, 15);
    check("result_data", m_data, 11);
    @(posedge clk);
    #1;
    check("frames_done_1", frames_done, 1);
    repeat (3) @(posedge clk);
    #1;
    check("busy_idle", busy, 0);
    check("single_issues", issues, 1);
    check("credits_back", dut.credits, 4);
    // back-to-back streaming
    issues = 0;
    stalls = 0;
    issue_cyc.delete();
    got.delete();
    for (int i = 0; i < 8; i++) send_frame(16 * (i + 1));
    s_valid = 0;
    for (int k = 0; k < 100 && got.size() < 8; k++) @(posedge clk);
    #1;
    check("stream_stalls", stalls, 0);
    check("stream_issues", issues, 8);
    check("stream_results", got.size(), 8);
    for (int i = 1; i < 8 && i < issue_cyc.size(); i++)
      check("issue_gap", issue_cyc[i] - issue_cyc[i-1], 10);
    for (int i = 0; i < got.size(); i++) check("stream_data", got[i], 32 * (i + 1) + 9);
    // backpressure: six frames against a stalled consumer
    m_ready = 0;
    issues = 0;
    got.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) send_frame(256 * (i + 1));
        s_valid = 0;
      end
    join_none
    repeat (130) @(posedge clk);
    #1;
    check("bp_issues", issues, 4);
    check("bp_fifo_count", dut.fifo_count, 4);
    check("bp_credits", dut.credits, 0);
    check("bp_hold_valid", dut.hold_valid, 1);
    check("bp_s_ready", s_ready, 0);
    check("bp_idx", dut.idx, 9);
    check("bp_held_frame", seg_bus[seg_lo(0) +: DATA_W], 256 * 5);
    check("bp_m_valid", m_valid, 1);
    m_ready = 1;
    wait fork;
    for (int k = 0; k < 200 && got.size() < 6; k++) @(posedge clk);
    #1;
    check("bp_results", got.size(), 6);
    for (int i = 0; i < got.size(); i++) check("bp_data", got[i], 512 * (i + 1) + 9);
    check("bp_total_issues", issues, 6);
    check("pop_issue_seen", both_any, 1);
    check("bp_frames_done", frames_done, 15);
    // asynchronous reset with one result buffered and one frame in flight
    m_ready = 0;
    got.delete();
    send_frame(4096);
    s_valid = 0;
    for (int k = 0; k < 40 && !m_valid; k++) @(posedge clk);
    #1;
    check("pre_rst_m_valid", m_valid, 1);
    send_frame(8192);
    s_valid = 0;
    check("pre_rst_issue", issue, 1);
    repeat (5) @(posedge clk);
    #2;
    check("pre_rst_busy", busy, 1);
    reset = 1;
    #1;
    check("async_m_valid", m_valid, 0);
    check("async_busy", busy, 0);
    check("async_credits", dut.credits, 4);
    check("async_s_ready", s_ready, 1);
    @(posedge clk);
    #1 reset = 0;
    m_ready = 1;
    repeat (30) @(posedge clk);
    #1;
    check("aborted_results", got.size(), 0);
    check("aborted_m_valid", m_valid, 0);
    check("aborted_frames_done", frames_done, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
